coin_acceptor: RTL and testbench
================================

Name: coin_acceptor

Overview:
- Upstream stage of fsm_vending.
- Takes raw, asynchronous, bouncy coin-sensor levels (one line per coin type) and synchronises and debounces them.
- Converts each clean insertion into exactly one single-cycle 3-bit coin code on the `in` bus of fsm_vending: 3'd1 = coin A, 3'd2 = coin B, 3'd0 = idle.
- Also serialises simultaneous insertions and flags jammed sensors.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required to change a debounced level; legal range 2..15.
- MAX_HOLD, 64: consecutive cycles of debounced-high after which a sensor is declared jammed; must exceed DEBOUNCE_CYCLES.
- CNT_W, 7: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state on rising edge.
- arstn  input  1  asynchronous active-low reset.
- coin_a_raw  input  1  raw sensor level, coin A; asynchronous to clk.
- coin_b_raw  input  1  raw sensor level, coin B; asynchronous to clk.
- accept_en  input  1  1 = insertions are reported; 0 = insertions are discarded.
- coin_code  output  3  registered; 3'd1 or 3'd2 for exactly one cycle per accepted coin, else 3'd0; drives fsm_vending `in`.
- jam  output  2  registered; bit0 = coin A jammed, bit1 = coin B jammed.

Behaviour:
- Reset is asynchronous, active-low; reset values:
  - coin_code = 0, jam = 0, pending flags = 0, counters = 0, sync flops = 0.
  - Debounced levels reset to 1 (sensor treated as occupied). A sensor held high through reset therefore produces no coin; it must be seen debounced-low before an insertion counts.
  - Reset mid-operation drops pending coins silently.
- Per channel (identical for A and B):
  - 2-flop synchroniser feeds the debounce stage.
  - Debounce: sync output != level → cnt increments; when cnt == DEBOUNCE_CYCLES-1 on a mismatching edge, level <= sync output and cnt <= 0. Any edge with sync output == level clears cnt.
  - Rise: asserted combinationally when level is 1 and level_d (level delayed one cycle) is 0.
  - Latency: with raw first sampled high at edge k and held, level rises at edge k+1+DEBOUNCE_CYCLES. coin_code is valid after edge k+2+DEBOUNCE_CYCLES (6 edges at default) for one cycle.
  - Glitches shorter than DEBOUNCE_CYCLES synchronised cycles produce no coin.
- Pending and arbitration:
  - Rise with accept_en = 1 sets the channel's pending flag. Rise with accept_en = 0 is discarded; pending is not set later.
  - Each cycle the registered output takes: pending A → 3'd1, else pending B → 3'd2, else 3'd0. The served flag clears on the same edge.
  - Simultaneous A and B rise: 3'd1 is emitted, then 3'd2 on the next cycle.
  - A new rise on a channel whose pending flag is still set is impossible: minimum same-channel spacing is 2*DEBOUNCE_CYCLES. Flag behaviour is OR (no second coin).
  - accept_en is not applied to already-pending coins; they are still emitted.
- Jam detection:
  - Hold counter runs while level = 1 and saturates at MAX_HOLD.
  - jam bit asserts on the edge at which the counter reaches MAX_HOLD.
  - jam bit clears on the edge at which level falls; counter clears with it.
  - The coin that started the hold has already been emitted and is not revoked.
  - Post-reset stuck-high also raises jam after MAX_HOLD cycles.
- coin_code is never 3'd3..3'd7.

Decomposition:
- Shared package coin_pkg:
  - localparams COIN_NONE = 3'd0, COIN_A = 3'd1, COIN_B = 3'd2.
  - Used by this block and fsm_vending.
- One sub-module, coin_channel: synchroniser, debounce counter, level_d, rise pulse, hold counter, jam flag. Instantiated twice.
- Top level holds the pending flags, arbiter and output register.

Test Plan:
- Reset with both raw low, release, then coin_a_raw high from edge k, held 20 cycles → coin_code = 3'd1 exactly in the cycle after edge k+6, 3'd0 elsewhere; jam stays 0.
- coin_b_raw 2-cycle high glitch, then low → coin_code stays 3'd0 throughout.
- Both raws rise on the same edge and are held → 3'd1 in one cycle, 3'd2 in the immediately following cycle, then 3'd0.
- accept_en = 0 while coin A inserted, then accept_en = 1 while raw is still high → no coin emitted; a subsequent clean A insertion emits 3'd1.
- coin_a_raw held high 80 cycles → one 3'd1, jam[0] = 1 from level-rise + 64 edges, jam[0] = 0 after raw drops and the debounce elapses; no extra coin.
- coin_b_raw high across reset and after release → no coin, jam[1] asserts after 64 cycles. Also assert arstn low one cycle before a pending 3'd2 would be emitted → no coin_code output.

Source files
------------

// File: rtl/coin_pkg.sv
// rtl/coin_pkg.sv - coin codes shared by coin_acceptor and fsm_vending
package coin_pkg;

  localparam logic [2:0] COIN_NONE = 3'd0;
  localparam logic [2:0] COIN_A    = 3'd1;
  localparam logic [2:0] COIN_B    = 3'd2;

  // Fixed priority: coin A is always served before coin B.
  function automatic logic [2:0] arbitrate(input logic want_a, input logic want_b);
    if (want_a)      return COIN_A;
    else if (want_b) return COIN_B;
    else             return COIN_NONE;
  endfunction

endpackage

// File: rtl/coin_channel.sv
// rtl/coin_channel.sv - one coin sensor: synchroniser, debounce, rise pulse, jam detect
module coin_channel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_HOLD        = 64,
  parameter int CNT_W           = 7
) (
  input  logic clk,
  input  logic arstn,
  input  logic raw,
  output logic rise,
  output logic jam
);

  localparam logic [3:0]       DB_LAST  = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_PRE = CNT_W'(MAX_HOLD - 1);

  logic             sync_1;
  logic             sync_2;
  logic [3:0]       db_cnt;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] hold_cnt;
  logic             mismatch;
  logic             flip;
  logic             level_next;

  always_comb begin
    mismatch   = (sync_2 != level);
    flip       = mismatch && (db_cnt == DB_LAST);
    level_next = flip ? sync_2 : level;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
    end
  end

  // Level resets high so a sensor occupied through reset never yields a coin.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      db_cnt  <= 4'd0;
      level   <= 1'b1;
      level_d <= 1'b1;
    end else begin
      level_d <= level;
      if (!mismatch) begin
        db_cnt <= 4'd0;
      end else if (flip) begin
        db_cnt <= 4'd0;
        level  <= sync_2;
      end else begin
        db_cnt <= db_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      hold_cnt <= '0;
      jam      <= 1'b0;
    end else if (!level_next) begin
      hold_cnt <= '0;
      jam      <= 1'b0;
    end else if (level && (hold_cnt != HOLD_MAX)) begin
      hold_cnt <= hold_cnt + CNT_W'(1);
      if (hold_cnt == HOLD_PRE) jam <= 1'b1;
    end
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - debounced dual coin sensor front end feeding fsm_vending
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_HOLD        = 64,
  parameter int CNT_W           = 7
) (
  input  logic       clk,
  input  logic       arstn,
  input  logic       coin_a_raw,
  input  logic       coin_b_raw,
  input  logic       accept_en,
  output logic [2:0] coin_code,
  output logic [1:0] jam
);

  logic       rise_a;
  logic       rise_b;
  logic       jam_a;
  logic       jam_b;
  logic       pend_a;
  logic       pend_b;
  logic       want_a;
  logic       want_b;
  logic [2:0] code_next;

  coin_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .MAX_HOLD       (MAX_HOLD),
    .CNT_W          (CNT_W)
  ) u_chan_a (
    .clk  (clk),
    .arstn(arstn),
    .raw  (coin_a_raw),
    .rise (rise_a),
    .jam  (jam_a)
  );

  coin_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .MAX_HOLD       (MAX_HOLD),
    .CNT_W          (CNT_W)
  ) u_chan_b (
    .clk  (clk),
    .arstn(arstn),
    .raw  (coin_b_raw),
    .rise (rise_b),
    .jam  (jam_b)
  );

  // A fresh rise is served on the same edge it would set pending.
  always_comb begin
    want_a    = pend_a | (rise_a & accept_en);
    want_b    = pend_b | (rise_b & accept_en);
    code_next = arbitrate(want_a, want_b);
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      coin_code <= COIN_NONE;
      pend_a    <= 1'b0;
      pend_b    <= 1'b0;
    end else begin
      coin_code <= code_next;
      pend_a    <= want_a && (code_next != COIN_A);
      pend_b    <= want_b && (code_next != COIN_B);
    end
  end

  assign jam = {jam_b, jam_a};

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - randomized and directed bench for coin_acceptor
module tb_coin_acceptor;

  localparam int DB   = 4;
  localparam int MAXH = 64;

  logic       clk = 1'b0;
  logic       arstn = 1'b0;
  logic       coin_a_raw = 1'b0;
  logic       coin_b_raw = 1'b0;
  logic       accept_en = 1'b0;
  logic [2:0] coin_code;
  logic [1:0] jam;

  int vectors = 0;
  int miscompares = 0;

  coin_acceptor #(
    .DEBOUNCE_CYCLES(DB),
    .MAX_HOLD       (MAXH),
    .CNT_W          (7)
  ) dut (
    .clk       (clk),
    .arstn     (arstn),
    .coin_a_raw(coin_a_raw),
    .coin_b_raw(coin_b_raw),
    .accept_en (accept_en),
    .coin_code (coin_code),
    .jam       (jam)
  );

  always #5 clk = ~clk;

  // Reference model: raw delayed two samples, level flips once the last DB
  // synchronised samples all disagree with it, coins queue as pending bits.
  bit         m_d1 [2];
  bit         m_d2 [2];
  logic [15:0] m_hist [2];
  int         m_hist_n [2];
  bit         m_lvl [2];
  bit         m_lvl_d [2];
  int         m_hold [2];
  bit         m_pa;
  bit         m_pb;
  logic [2:0] m_code;
  logic [1:0] m_jam;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_d1[c] = 0; m_d2[c] = 0; m_hist[c] = '0; m_hist_n[c] = 0;
      m_lvl[c] = 1; m_lvl_d[c] = 1; m_hold[c] = 0;
    end
    m_pa = 0; m_pb = 0; m_code = 3'd0; m_jam = 2'b00;
  endtask

  task automatic model_step();
    bit raw [2];
    bit newc [2];
    bit s;
    bit flip;
    bit nl;
    raw[0] = coin_a_raw;
    raw[1] = coin_b_raw;
    for (int c = 0; c < 2; c++) begin
      s = m_d2[c];
      m_d2[c] = m_d1[c];
      m_d1[c] = raw[c];
      newc[c] = m_lvl[c] && !m_lvl_d[c] && accept_en;
      m_hist[c] = {m_hist[c][14:0], s};
      if (m_hist_n[c] < 16) m_hist_n[c]++;
      flip = (m_hist_n[c] >= DB);
      for (int i = 0; i < DB; i++) if (m_hist[c][i] == m_lvl[c]) flip = 0;
      nl = flip ? !m_lvl[c] : m_lvl[c];
      if (!nl) m_hold[c] = 0;
      else if (m_lvl[c] && m_hold[c] < MAXH) m_hold[c]++;
      m_jam[c] = nl && (m_hold[c] >= MAXH);
      m_lvl_d[c] = m_lvl[c];
      m_lvl[c] = nl;
    end
    m_pa = m_pa | newc[0];
    m_pb = m_pb | newc[1];
    if (m_pa) begin m_code = 3'd1; m_pa = 0; end
    else if (m_pb) begin m_code = 3'd2; m_pb = 0; end
    else m_code = 3'd0;
  endtask

  always @(posedge clk or negedge arstn) begin
    if (!arstn) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    vectors++;
    if (coin_code !== m_code || jam !== m_jam) begin
      miscompares++;
      $display("FAIL model t=%0t coin_code=%0d jam=%b expected coin_code=%0d jam=%b",
               $time, coin_code, jam, m_code, m_jam);
    end
  end

  task automatic check_lit(input string name, input logic [2:0] code_exp, input logic [1:0] jam_exp);
    vectors++;
    if (coin_code !== code_exp || jam !== jam_exp) begin
      miscompares++;
      $display("FAIL %s t=%0t coin_code=%0d jam=%b expected coin_code=%0d jam=%b",
               name, $time, coin_code, jam, code_exp, jam_exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic tick_check(input string name, input logic [2:0] code_exp, input logic [1:0] jam_exp);
    @(negedge clk);
    #1;
    check_lit(name, code_exp, jam_exp);
  endtask

  int cnt_a;
  int cnt_b;
  bit seen;

  initial begin
    #1;
    check_lit("reset", 3'd0, 2'b00);
    idle(2);
    arstn = 1'b1;
    idle(10);
    accept_en = 1'b1;

    // Clean coin A: code 1 after edge k+6 only.
    coin_a_raw = 1'b1;
    for (int j = 0; j < 20; j++) tick_check("coin_a", (j == 6) ? 3'd1 : 3'd0, 2'b00);
    #1; coin_a_raw = 1'b0;
    idle(12);

    // Two-sample glitch on B.
    coin_b_raw = 1'b1;
    @(negedge clk); @(negedge clk); #2;
    coin_b_raw = 1'b0;
    for (int j = 0; j < 12; j++) tick_check("glitch_b", 3'd0, 2'b00);
    #1;

    // Simultaneous insertion.
    coin_a_raw = 1'b1; coin_b_raw = 1'b1;
    for (int j = 0; j < 16; j++)
      tick_check("both", (j == 6) ? 3'd1 : ((j == 7) ? 3'd2 : 3'd0), 2'b00);
    #1; coin_a_raw = 1'b0; coin_b_raw = 1'b0;
    idle(12);

    // Rise while disabled is discarded even after re-enable.
    accept_en = 1'b0;
    coin_a_raw = 1'b1;
    for (int j = 0; j < 10; j++) tick_check("disabled", 3'd0, 2'b00);
    #1; accept_en = 1'b1;
    for (int j = 0; j < 10; j++) tick_check("reenabled", 3'd0, 2'b00);
    #1; coin_a_raw = 1'b0;
    idle(12);
    coin_a_raw = 1'b1;
    for (int j = 0; j < 12; j++) tick_check("after_en", (j == 6) ? 3'd1 : 3'd0, 2'b00);
    #1; coin_a_raw = 1'b0;
    idle(12);

    // Jam on A: jam after edge k+69, clears 5 edges after raw drop.
    coin_a_raw = 1'b1;
    for (int j = 0; j < 80; j++)
      tick_check("jam_a", (j == 6) ? 3'd1 : 3'd0, (j >= 69) ? 2'b01 : 2'b00);
    #1; coin_a_raw = 1'b0;
    for (int j = 0; j < 12; j++) tick_check("unjam_a", 3'd0, (j < 5) ? 2'b01 : 2'b00);
    #1;

    // Reset just before pending B is emitted, sensors held through reset.
    coin_a_raw = 1'b1; coin_b_raw = 1'b1;
    seen = 0;
    for (int j = 0; j < 20 && !seen; j++) begin
      @(negedge clk); #1;
      if (coin_code == 3'd1) seen = 1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL wait_coin_a timeout coin_code=%0d expected 1", coin_code);
    end
    arstn = 1'b0;
    #1;
    check_lit("reset_drop", 3'd0, 2'b00);
    @(negedge clk); #2;
    arstn = 1'b1;
    for (int j = 1; j <= 70; j++)
      tick_check("stuck_reset", 3'd0, (j >= 64) ? 2'b11 : 2'b00);
    #1; coin_a_raw = 1'b0; coin_b_raw = 1'b0;
    idle(15);

    // Random phase, checked by the model process.
    cnt_a = 0; cnt_b = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      #($urandom_range(1, 4));
      if (cnt_a == 0) begin
        coin_a_raw = $urandom_range(0, 1);
        cnt_a = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 90) : $urandom_range(1, 12);
      end else cnt_a--;
      if (cnt_b == 0) begin
        coin_b_raw = $urandom_range(0, 1);
        cnt_b = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 90) : $urandom_range(1, 12);
      end else cnt_b--;
      if ($urandom_range(0, 39) == 0) accept_en = ~accept_en;
      if (cyc == 2000) begin
        arstn = 1'b0;
        #1;
        arstn = 1'b1;
      end
    end
    coin_a_raw = 1'b0; coin_b_raw = 1'b0; accept_en = 1'b1;
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
